// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM->WB pipeline stage: control bundle, occupancy states
// and default widths.
package mem_wb_pkg;

    localparam int DEFAULT_DATA_W = 24;
    localparam int DEFAULT_ALU_W  = 16;
    localparam int DEFAULT_ADDR_W = 4;

    typedef struct packed {
        logic PCSrc;
        logic regWrite;
        logic memToReg;
    } mem_wb_ctrl_t;

    // Encoded as {main_valid, skid_valid}; 2'b01 cannot be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b10,
        SKID  = 2'b11
    } mem_wb_state_t;

    function automatic mem_wb_ctrl_t gate_ctrl(input mem_wb_ctrl_t ctrl, input logic valid);
        return valid ? ctrl : '0;
    endfunction

endpackage

// File: rtl/mem_wb_slot.sv
// One payload register plus valid bit; the parent decides when the payload
// loads and what the valid bit becomes each cycle.
module mem_wb_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         valid_next,
    input  logic [W-1:0] data_in,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= valid_next;
            if (load) begin
                data <= data_in;
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, flush and a one-entry skid
// buffer so writeback back-pressure never reaches the memory stage combinationally.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ALU_W  = DEFAULT_ALU_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] RD,
    input  logic [ALU_W-1:0]  ALUOutM,
    input  logic [ADDR_W-1:0] WA3M,
    input  logic              PCSrcM,
    input  logic              regWriteM,
    input  logic              memToRegM,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ReadData,
    output logic [DATA_W-1:0] AluOutW,
    output logic [ADDR_W-1:0] WA3W,
    output logic              PCSrcW,
    output logic              regWriteW,
    output logic              memToRegW,
    output logic [DATA_W-1:0] ResultW
);

    typedef struct packed {
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] alu;
        logic [ADDR_W-1:0] wa3;
        mem_wb_ctrl_t      ctrl;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    payload_t      in_payload;
    payload_t      main_q;
    payload_t      skid_q;
    payload_t      main_d;
    logic          main_valid;
    logic          skid_valid;
    logic          main_valid_next;
    logic          skid_valid_next;
    logic          main_load;
    logic          skid_load;
    logic          main_from_skid;
    logic          accept;
    logic          drain;
    mem_wb_ctrl_t  ctrl_w;
    mem_wb_state_t state;

    // ALU result is zero-extended here so everything downstream is DATA_W wide.
    always_comb begin
        in_payload               = '0;
        in_payload.rd            = RD;
        in_payload.alu           = DATA_W'(ALUOutM);
        in_payload.wa3           = WA3M;
        in_payload.ctrl.PCSrc    = PCSrcM;
        in_payload.ctrl.regWrite = regWriteM;
        in_payload.ctrl.memToReg = memToRegM;
    end

    assign state    = mem_wb_state_t'({main_valid, skid_valid});
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid && out_ready;

    always_comb begin
        main_load       = 1'b0;
        skid_load       = 1'b0;
        main_from_skid  = 1'b0;
        main_valid_next = main_valid;
        skid_valid_next = skid_valid;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_load       = 1'b1;
                        main_valid_next = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load       = 1'b1;
                        skid_valid_next = 1'b1;
                    end else if (drain) begin
                        main_valid_next = 1'b0;
                    end
                end
                SKID: begin
                    if (drain) begin
                        main_load       = 1'b1;
                        main_from_skid  = 1'b1;
                        skid_valid_next = 1'b0;
                    end
                end
                default: begin
                    main_valid_next = 1'b0;
                    skid_valid_next = 1'b0;
                end
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_payload;

    mem_wb_slot #(.W(PAYLOAD_W)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (main_load),
        .valid_next (main_valid_next),
        .data_in    (main_d),
        .valid      (main_valid),
        .data       (main_q)
    );

    mem_wb_slot #(.W(PAYLOAD_W)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .valid_next (skid_valid_next),
        .data_in    (in_payload),
        .valid      (skid_valid),
        .data       (skid_q)
    );

    // Control bits are masked by valid so a bubble can never write the register file.
    assign ctrl_w    = gate_ctrl(main_q.ctrl, main_valid);
    assign out_valid = main_valid;
    assign ReadData  = main_q.rd;
    assign AluOutW   = main_q.alu;
    assign WA3W      = main_q.wa3;
    assign PCSrcW    = ctrl_w.PCSrc;
    assign regWriteW = ctrl_w.regWrite;
    assign memToRegW = ctrl_w.memToReg;
    assign ResultW   = ctrl_w.memToReg ? main_q.rd : main_q.alu;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, then a FIFO
// scoreboard driving handshake, flush, reset and random traffic.
module tb_mem_wb_stage;

    localparam int DATA_W = 24;
    localparam int ALU_W  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] RD = '0;
    logic [ALU_W-1:0]  ALUOutM = '0;
    logic [ADDR_W-1:0] WA3M = '0;
    logic              PCSrcM = 1'b0;
    logic              regWriteM = 1'b0;
    logic              memToRegM = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] ReadData;
    logic [DATA_W-1:0] AluOutW;
    logic [ADDR_W-1:0] WA3W;
    logic              PCSrcW;
    logic              regWriteW;
    logic              memToRegW;
    logic [DATA_W-1:0] ResultW;

    mem_wb_stage #(.DATA_W(DATA_W), .ALU_W(ALU_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .RD        (RD),
        .ALUOutM   (ALUOutM),
        .WA3M      (WA3M),
        .PCSrcM    (PCSrcM),
        .regWriteM (regWriteM),
        .memToRegM (memToRegM),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ReadData  (ReadData),
        .AluOutW   (AluOutW),
        .WA3W      (WA3W),
        .PCSrcW    (PCSrcW),
        .regWriteW (regWriteW),
        .memToRegW (memToRegW),
        .ResultW   (ResultW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] rd;
        logic [ALU_W-1:0]  alu;
        logic [ADDR_W-1:0] wa3;
        logic              pc;
        logic              rw;
        logic              m2r;
    } payload_t;

    typedef struct {
        logic              v;
        payload_t          p;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_alu;
        logic [DATA_W-1:0] exp_result;
        logic [ADDR_W-1:0] exp_wa3;
        logic              exp_rw;
        logic              exp_pc;
    } vec_t;

    payload_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic f, input payload_t p);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        RD        = p.rd;
        ALUOutM   = p.alu;
        WA3M      = p.wa3;
        PCSrcM    = p.pc;
        regWriteM = p.rw;
        memToRegM = p.m2r;
    endtask

    // Expected outputs come from the scoreboard head; an empty scoreboard means a bubble.
    task automatic check_output(input string name);
        logic [DATA_W-1:0] alu_ext;
        payload_t          h;
        cmp({name, ".in_ready"}, 128'(in_ready), 128'(sb.size() < 2));
        if (sb.size() == 0) begin
            cmp({name, ".bubble"}, 128'({out_valid, PCSrcW, regWriteW, memToRegW}), 128'(0));
        end else begin
            h       = sb[0];
            alu_ext = {{(DATA_W-ALU_W){1'b0}}, h.alu};
            cmp({name, ".payload"},
                128'({out_valid, ReadData, AluOutW, WA3W, PCSrcW, regWriteW, memToRegW, ResultW}),
                128'({1'b1, h.rd, alu_ext, h.wa3, h.pc, h.rw, h.m2r, h.m2r ? h.rd : alu_ext}));
        end
    endtask

    // Called just after a negedge: drive, check current outputs, advance model, run one edge.
    task automatic apply_stimulus(input string name, input logic v, input logic r,
                                  input logic f, input payload_t p);
        logic acc;
        logic drn;
        drive(v, r, f, p);
        check_output(name);
        acc = v && (sb.size() < 2);
        drn = (sb.size() > 0) && r;
        if (f) begin
            sb.delete();
        end else begin
            if (drn) void'(sb.pop_front());
            if (acc) sb.push_back(p);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic payload_t rand_payload();
        payload_t p;
        p.rd  = DATA_W'($urandom);
        p.alu = ALU_W'($urandom);
        p.wa3 = ADDR_W'($urandom);
        p.pc  = 1'($urandom);
        p.rw  = 1'($urandom);
        p.m2r = 1'($urandom);
        return p;
    endfunction

    assert property (@(posedge clk) disable iff (!rst_n) !(!dut.main_valid && dut.skid_valid))
        else begin
            errors++;
            $display("[TB] FAIL state01 reached at %0t", $time);
        end

    assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=>
            $stable({ReadData, AluOutW, WA3W, PCSrcW, regWriteW, memToRegW, ResultW}))
        else begin
            errors++;
            $display("[TB] FAIL stable outputs changed while stalled at %0t", $time);
        end

    initial begin
        vec_t     vecs[5];
        payload_t a;
        payload_t b;
        payload_t c;
        payload_t z;

        z = '0;
        vecs[0] = '{1'b1, '{24'hABCDEF, 16'h1234, 4'd5, 1'b0, 1'b1, 1'b0},
                    1'b1, 24'h001234, 24'h001234, 4'd5, 1'b1, 1'b0};
        vecs[1] = '{1'b1, '{24'hABCDEF, 16'h1234, 4'd5, 1'b0, 1'b1, 1'b1},
                    1'b1, 24'h001234, 24'hABCDEF, 4'd5, 1'b1, 1'b0};
        vecs[2] = '{1'b0, '0, 1'b0, 24'h0, 24'h0, 4'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, '{24'h000000, 16'hFFFF, 4'hF, 1'b1, 1'b0, 1'b0},
                    1'b1, 24'h00FFFF, 24'h00FFFF, 4'hF, 1'b0, 1'b1};
        vecs[4] = '{1'b0, '0, 1'b0, 24'h0, 24'h0, 4'd0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        cmp("reset.outputs",
            128'({out_valid, ReadData, AluOutW, WA3W, PCSrcW, regWriteW, memToRegW, ResultW}), 128'(0));
        cmp("reset.in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].v, 1'b1, 1'b0, vecs[i].p);
            @(posedge clk);
            @(negedge clk);
            cmp($sformatf("vec%0d.valid", i), 128'({out_valid, regWriteW, PCSrcW}),
                128'({vecs[i].exp_valid, vecs[i].exp_rw, vecs[i].exp_pc}));
            cmp($sformatf("vec%0d.in_ready", i), 128'(in_ready), 128'(1));
            if (vecs[i].exp_valid) begin
                cmp($sformatf("vec%0d.data", i), 128'({AluOutW, ResultW, WA3W}),
                    128'({vecs[i].exp_alu, vecs[i].exp_result, vecs[i].exp_wa3}));
            end
        end

        for (int i = 0; i < 8; i++) apply_stimulus("stream", 1'b1, 1'b1, 1'b0, rand_payload());
        apply_stimulus("stream_tail", 1'b0, 1'b1, 1'b0, z);

        a = rand_payload();
        b = rand_payload();
        apply_stimulus("bp_a", 1'b1, 1'b0, 1'b0, a);
        apply_stimulus("bp_b", 1'b1, 1'b0, 1'b0, b);
        apply_stimulus("bp_hold", 1'b1, 1'b0, 1'b0, rand_payload());
        apply_stimulus("bp_hold", 1'b0, 1'b0, 1'b0, z);
        for (int i = 0; i < 3; i++) apply_stimulus("bp_release", 1'b0, 1'b1, 1'b0, z);

        c = rand_payload();
        apply_stimulus("fl_a", 1'b1, 1'b0, 1'b0, a);
        apply_stimulus("fl_b", 1'b1, 1'b0, 1'b0, b);
        apply_stimulus("fl_skid", 1'b1, 1'b0, 1'b1, c);
        for (int i = 0; i < 2; i++) apply_stimulus("fl_after", 1'b0, 1'b1, 1'b0, z);

        apply_stimulus("fd_a", 1'b1, 1'b0, 1'b0, a);
        apply_stimulus("fd_flush_drain", 1'b0, 1'b1, 1'b1, z);
        apply_stimulus("fd_after", 1'b0, 1'b1, 1'b0, z);

        apply_stimulus("rst_a", 1'b1, 1'b0, 1'b0, a);
        apply_stimulus("rst_b", 1'b1, 1'b0, 1'b0, b);
        #2 rst_n = 1'b0;
        #1;
        cmp("async_reset.outputs",
            128'({out_valid, ReadData, AluOutW, WA3W, PCSrcW, regWriteW, memToRegW, ResultW}), 128'(0));
        cmp("async_reset.in_ready", 128'(in_ready), 128'(1));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus("post_reset_a", 1'b1, 1'b1, 1'b0, c);
        apply_stimulus("post_reset_b", 1'b0, 1'b1, 1'b0, z);

        for (int i = 0; i < 10000; i++) begin
            apply_stimulus("random", 1'($urandom), 1'($urandom), ($urandom_range(0, 31) == 0),
                           rand_payload());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
